// File: rtl/z_writeback.sv
// Result stage after the ALU: captures the 64-bit result into Z and writes it back
// over a 32-bit valid/ready bus (LO then HI for MUL/DIV, one GPR word otherwise).
module z_writeback #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*DATA_W-1:0]   alu_c,
    input  logic [3:0]            alu_select,
    input  logic                  start,
    input  logic                  flush,
    input  logic                  bus_ready,
    output logic [DATA_W-1:0]     bus_out,
    output logic                  bus_valid,
    output logic [1:0]            dest,
    output logic [2*DATA_W-1:0]   z_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int unsigned Z_W = 2 * DATA_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WB_LO = 2'd1;
    localparam logic [1:0] ST_WB_HI = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] DEST_NONE = 2'b00;
    localparam logic [1:0] DEST_GPR  = 2'b01;
    localparam logic [1:0] DEST_LO   = 2'b10;
    localparam logic [1:0] DEST_HI   = 2'b11;

    // Op codes that produce any writeback at all.
    function automatic logic op_defined(input logic [3:0] sel);
        logic res;
        case (sel)
            4'b0000, 4'b0100, 4'b1001, 4'b1011: res = 1'b0;
            default:                            res = 1'b1;
        endcase
        return res;
    endfunction

    // MUL and DIV produce a two-word result.
    function automatic logic op_wide(input logic [3:0] sel);
        return (sel == 4'b0011) || (sel == 4'b0101);
    endfunction

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [3:0]        sel_q;
    logic [3:0]        sel_n;
    logic [Z_W-1:0]    z_n;
    logic              overrun_n;
    logic [DATA_W-1:0] bus_out_n;
    logic              bus_valid_n;
    logic [1:0]        dest_n;
    logic              busy_n;
    logic              done_n;
    logic              xfer;

    assign xfer = bus_valid & bus_ready;

    // Next state, captured operands, and registered outputs derived from the next state.
    always_comb begin
        state_n     = state;
        sel_n       = sel_q;
        z_n         = z_out;
        overrun_n   = overrun | (start & (state != ST_IDLE));
        bus_out_n   = '0;
        bus_valid_n = 1'b0;
        dest_n      = DEST_NONE;
        done_n      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    z_n     = alu_c;
                    sel_n   = alu_select;
                    state_n = op_defined(alu_select) ? ST_WB_LO : ST_DONE;
                end
            end
            ST_WB_LO: begin
                if (xfer) state_n = op_wide(sel_q) ? ST_WB_HI : ST_DONE;
            end
            ST_WB_HI: begin
                if (xfer) state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (flush) state_n = ST_IDLE;

        case (state_n)
            ST_WB_LO: begin
                bus_valid_n = 1'b1;
                bus_out_n   = z_n[DATA_W-1:0];
                dest_n      = op_wide(sel_n) ? DEST_LO : DEST_GPR;
            end
            ST_WB_HI: begin
                bus_valid_n = 1'b1;
                bus_out_n   = z_n[Z_W-1:DATA_W];
                dest_n      = DEST_HI;
            end
            ST_DONE: done_n = 1'b1;
            default: ;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            z_out     <= '0;
            overrun   <= 1'b0;
            bus_out   <= '0;
            bus_valid <= 1'b0;
            dest      <= DEST_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sel_q     <= sel_n;
            z_out     <= z_n;
            overrun   <= overrun_n;
            bus_out   <= bus_out_n;
            bus_valid <= bus_valid_n;
            dest      <= dest_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_z_writeback.sv
// Bench for z_writeback: directed scenarios plus a randomized run checked
// against a queue-based model of the expected bus transfers.
module tb_z_writeback;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [63:0]       alu_c = '0;
    logic [3:0]        alu_select = '0;
    logic              start = 1'b0;
    logic              flush = 1'b0;
    logic              bus_ready = 1'b0;
    logic [31:0]       bus_out;
    logic              bus_valid;
    logic [1:0]        dest;
    logic [63:0]       z_out;
    logic              busy;
    logic              done;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  dest;
    } xfer_t;

    z_writeback #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .alu_c(alu_c), .alu_select(alu_select),
        .start(start), .flush(flush), .bus_ready(bus_ready),
        .bus_out(bus_out), .bus_valid(bus_valid), .dest(dest), .z_out(z_out),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({bus_valid, dest, bus_out, busy, done, overrun} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%b o=%h busy=%b done=%b ovr=%b expected all 0",
                     bus_valid, dest, bus_out, busy, done, overrun);
        end
        checks++;
        if (z_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_z: got %h expected 0", z_out);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        bus_ready = 1'b1; alu_select = 4'b0110; alu_c = 64'h0000_0000_00FF_00F0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({bus_valid, dest, bus_out} !== {1'b1, 2'b01, 32'h00FF_00F0}) begin
            errors++;
            $display("FAIL single_word: got v=%b d=%b o=%h expected v=1 d=01 o=00ff00f0", bus_valid, dest, bus_out);
        end
        step();
        checks++;
        if ({done, bus_valid, dest, busy} !== {1'b1, 1'b0, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL single_done: got done=%b v=%b d=%b busy=%b expected 1 0 00 1", done, bus_valid, dest, busy);
        end
        step();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_muldiv();
        bus_ready = 1'b1; alu_select = 4'b0011; alu_c = 64'h0000_0001_FFFF_FFFE; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({bus_valid, dest, bus_out} !== {1'b1, 2'b10, 32'hFFFF_FFFE}) begin
            errors++;
            $display("FAIL mul_lo: got v=%b d=%b o=%h expected v=1 d=10 o=fffffffe", bus_valid, dest, bus_out);
        end
        step();
        checks++;
        if ({bus_valid, dest, bus_out} !== {1'b1, 2'b11, 32'h0000_0001}) begin
            errors++;
            $display("FAIL mul_hi: got v=%b d=%b o=%h expected v=1 d=11 o=00000001", bus_valid, dest, bus_out);
        end
        step();
        checks++;
        if ({done, bus_valid} !== 2'b10) begin
            errors++;
            $display("FAIL mul_done: got done=%b v=%b expected 1 0", done, bus_valid);
        end
        step();
    endtask

    task automatic test_stall();
        logic [63:0] val;
        val = {$urandom, $urandom};
        bus_ready = 1'b1; alu_select = 4'b0101; alu_c = val; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({bus_valid, dest, bus_out} !== {1'b1, 2'b10, val[31:0]}) begin
            errors++;
            $display("FAIL div_lo: got v=%b d=%b o=%h expected v=1 d=10 o=%h", bus_valid, dest, bus_out, val[31:0]);
        end
        step();
        bus_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus_valid, dest, bus_out, done} !== {1'b1, 2'b11, val[63:32], 1'b0}) begin
                errors++;
                $display("FAIL div_stall_%0d: got v=%b d=%b o=%h done=%b expected v=1 d=11 o=%h done=0",
                         i, bus_valid, dest, bus_out, done, val[63:32]);
            end
        end
        bus_ready = 1'b1;
        step();
        checks++;
        if ({done, bus_valid} !== 2'b10) begin
            errors++;
            $display("FAIL div_stall_done: got done=%b v=%b expected 1 0", done, bus_valid);
        end
        step();
    endtask

    task automatic test_undefined();
        logic [3:0] undef_ops [4];
        logic [63:0] val;
        undef_ops = '{4'b0000, 4'b0100, 4'b1001, 4'b1011};
        for (int i = 0; i < 4; i++) begin
            val = {$urandom, $urandom};
            bus_ready = 1'b1; alu_select = undef_ops[i]; alu_c = val; start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if ({done, bus_valid, dest, z_out} !== {1'b1, 1'b0, 2'b00, val}) begin
                errors++;
                $display("FAIL undef_%0d: got done=%b v=%b d=%b z=%h expected 1 0 00 %h",
                         i, done, bus_valid, dest, z_out, val);
            end
            step();
        end
    endtask

    task automatic test_flush();
        logic [63:0] prev_z;
        logic [63:0] val;
        prev_z = z_out;
        bus_ready = 1'b1; alu_select = 4'b0110; alu_c = ~prev_z; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        checks++;
        if ({busy, overrun, bus_valid, z_out} !== {3'b000, prev_z}) begin
            errors++;
            $display("FAIL flush_start: got busy=%b ovr=%b v=%b z=%h expected 0 0 0 %h",
                     busy, overrun, bus_valid, z_out, prev_z);
        end
        val = {$urandom, $urandom};
        alu_select = 4'b0011; alu_c = val; start = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({busy, done, bus_valid, dest} !== 5'b0) begin
            errors++;
            $display("FAIL flush_wb_lo: got busy=%b done=%b v=%b d=%b expected all 0", busy, done, bus_valid, dest);
        end
        step();
        checks++;
        if ({busy, done, z_out} !== {2'b00, val}) begin
            errors++;
            $display("FAIL flush_after: got busy=%b done=%b z=%h expected 0 0 %h", busy, done, z_out, val);
        end
    endtask

    task automatic test_overrun();
        logic [63:0] val;
        val = {$urandom, $urandom};
        bus_ready = 1'b0; alu_select = 4'b0101; alu_c = val; start = 1'b1;
        step();
        alu_c = ~val; alu_select = 4'b0110;
        step();
        start = 1'b0;
        checks++;
        if ({overrun, z_out, bus_valid, dest, bus_out} !== {1'b1, val, 1'b1, 2'b10, val[31:0]}) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b z=%h v=%b d=%b o=%h expected 1 %h 1 10 %h",
                     overrun, z_out, bus_valid, dest, bus_out, val, val[31:0]);
        end
        bus_ready = 1'b1;
        step();
        step();
        checks++;
        if ({done, overrun} !== 2'b11) begin
            errors++;
            $display("FAIL overrun_done: got done=%b ovr=%b expected 1 1", done, overrun);
        end
        step();
        step();
        checks++;
        if ({busy, overrun} !== 2'b01) begin
            errors++;
            $display("FAIL overrun_sticky: got busy=%b ovr=%b expected 0 1", busy, overrun);
        end
    endtask

    task automatic test_reset_mid();
        bus_ready = 1'b1; alu_select = 4'b0011; alu_c = {$urandom, $urandom}; start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({bus_valid, dest} !== 3'b111) begin
            errors++;
            $display("FAIL reset_mid_pre: got v=%b d=%b expected 1 11", bus_valid, dest);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus_valid, dest, bus_out, busy, done, overrun, z_out} !== 102'h0) begin
            errors++;
            $display("FAIL reset_async: got v=%b d=%b o=%h busy=%b done=%b ovr=%b z=%h expected all 0",
                     bus_valid, dest, bus_out, busy, done, overrun, z_out);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_random();
        xfer_t       q[$];
        logic [63:0] val;
        logic [3:0]  sel;
        logic        r;
        bit          finished;
        for (int n = 0; n < 40; n++) begin
            val = {$urandom, $urandom};
            sel = 4'($urandom_range(0, 15));
            q.delete();
            if (sel inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, [4'd12:4'd15]}) begin
                if (sel inside {4'd3, 4'd5}) begin
                    q.push_back('{data: val[31:0], dest: 2'b10});
                    q.push_back('{data: val[63:32], dest: 2'b11});
                end else begin
                    q.push_back('{data: val[31:0], dest: 2'b01});
                end
            end
            alu_select = sel; alu_c = val; start = 1'b1; bus_ready = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            finished = 1'b0;
            for (int c = 0; c < 64 && !finished; c++) begin
                if (q.size() > 0) begin
                    checks++;
                    if ({bus_valid, dest, bus_out, done} !== {1'b1, q[0].dest, q[0].data, 1'b0}) begin
                        errors++;
                        $display("FAIL rand_%0d_xfer: got v=%b d=%b o=%h done=%b expected 1 %b %h 0",
                                 n, bus_valid, dest, bus_out, done, q[0].dest, q[0].data);
                    end
                    r = 1'($urandom_range(0, 1));
                    bus_ready = r;
                    step();
                    if (r) void'(q.pop_front());
                end else begin
                    checks++;
                    if ({done, bus_valid, busy, z_out, overrun} !== {3'b101, val, 1'b0}) begin
                        errors++;
                        $display("FAIL rand_%0d_done: got done=%b v=%b busy=%b z=%h ovr=%b expected 1 0 1 %h 0",
                                 n, done, bus_valid, busy, z_out, overrun, val);
                    end
                    step();
                    finished = 1'b1;
                end
            end
            if (!finished) begin
                checks++;
                errors++;
                $display("FAIL rand_%0d_timeout: got no completion expected done within 64 cycles", n);
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_muldiv();
        test_stall();
        test_undefined();
        test_flush();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
